// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode front end: reads one- or two-byte instructions from
// memory, owns the PC, and presents decoded instructions on a valid/ready port.
module instr_fetch_decode #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_rd_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [7:0]        mem_rdata_i,
   output logic              dec_valid_o,
   input  logic              dec_ready_i,
   output logic [3:0]        dec_opcode_o,
   output logic [1:0]        dec_rd_o,
   output logic [1:0]        dec_rs_o,
   output logic [7:0]        dec_operand_o,
   output logic [ADDR_W-1:0] dec_pc_o,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_addr_i
);

   typedef enum logic [1:0] {FETCH, DEC, IMM, ISSUE} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [7:0]        ir_q;
   logic              decValid_q;
   logic [3:0]        decOpcode_q;
   logic [1:0]        decRd_q;
   logic [1:0]        decRs_q;
   logic [7:0]        decOperand_q;
   logic [ADDR_W-1:0] decPc_q;
   logic              needOperand;

   // Opcodes 8..15 carry a second byte, so the top opcode bit alone decides it.
   assign needOperand = (state_q == DEC) && mem_rdata_i[7];

   // The read strobe is forced low while reset is held so the memory sees no
   // spurious access even though the FSM rests in FETCH.
   assign mem_rd_o   = !rst && ((state_q == FETCH) || needOperand);
   assign mem_addr_o = needOperand ? pc_q + ADDR_W'(1) : pc_q;

   assign dec_valid_o   = decValid_q;
   assign dec_opcode_o  = decOpcode_q;
   assign dec_rd_o      = decRd_q;
   assign dec_rs_o      = decRs_q;
   assign dec_operand_o = decOperand_q;
   assign dec_pc_o      = decPc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         ir_q         <= '0;
         decValid_q   <= 1'b0;
         decOpcode_q  <= '0;
         decRd_q      <= '0;
         decRs_q      <= '0;
         decOperand_q <= '0;
         decPc_q      <= '0;
      end else if (redirect_i) begin
         // Redirect wins everywhere; decoded fields keep their last values.
         state_q    <= FETCH;
         pc_q       <= redirect_addr_i;
         decValid_q <= 1'b0;
      end else begin
         case (state_q)
            FETCH: begin
               state_q <= DEC;
            end
            DEC: begin
               ir_q <= mem_rdata_i;
               if (mem_rdata_i[7]) begin
                  state_q <= IMM;
               end else begin
                  decOpcode_q  <= mem_rdata_i[7:4];
                  decRd_q      <= mem_rdata_i[3:2];
                  decRs_q      <= mem_rdata_i[1:0];
                  decOperand_q <= 8'd0;
                  decPc_q      <= pc_q;
                  decValid_q   <= 1'b1;
                  pc_q         <= pc_q + ADDR_W'(1);
                  state_q      <= ISSUE;
               end
            end
            IMM: begin
               decOpcode_q  <= ir_q[7:4];
               decRd_q      <= ir_q[3:2];
               decRs_q      <= ir_q[1:0];
               decOperand_q <= mem_rdata_i;
               decPc_q      <= pc_q;
               decValid_q   <= 1'b1;
               pc_q         <= pc_q + ADDR_W'(2);
               state_q      <= ISSUE;
            end
            ISSUE: begin
               if (dec_ready_i) begin
                  decValid_q <= 1'b0;
                  state_q    <= FETCH;
               end
            end
            default: begin
               state_q <= FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: a byte memory model answers reads one
// cycle later, and a scoreboard monitor checks every accepted instruction.
module tb_instr_fetch_decode;

   typedef struct packed {
      logic [3:0] op;
      logic [1:0] rd;
      logic [1:0] rs;
      logic [7:0] operand;
      logic [7:0] pc;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       memRd;
   logic [7:0] memAddr;
   logic [7:0] memRdata;
   logic       decValid;
   logic       decReady;
   logic [3:0] decOpcode;
   logic [1:0] decRd;
   logic [1:0] decRs;
   logic [7:0] decOperand;
   logic [7:0] decPc;
   logic       redirect;
   logic [7:0] redirectAddr;

   logic [7:0] mem [256];
   exp_t       expQ [$];
   int         compared;
   int         mismatched;

   instr_fetch_decode #(.ADDR_W(8), .RESET_PC(8'd0)) dut (
      .clk             (clk),
      .rst             (rst),
      .mem_rd_o        (memRd),
      .mem_addr_o      (memAddr),
      .mem_rdata_i     (memRdata),
      .dec_valid_o     (decValid),
      .dec_ready_i     (decReady),
      .dec_opcode_o    (decOpcode),
      .dec_rd_o        (decRd),
      .dec_rs_o        (decRs),
      .dec_operand_o   (decOperand),
      .dec_pc_o        (decPc),
      .redirect_i      (redirect),
      .redirect_addr_i (redirectAddr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read data appears one cycle after the strobe; garbage otherwise.
   always @(posedge clk) begin
      if (memRd) memRdata <= mem[memAddr];
      else       memRdata <= 8'($urandom);
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic ready, input logic redir, input logic [7:0] raddr);
      @(posedge clk);
      #1;
      decReady     = ready;
      redirect     = redir;
      redirectAddr = raddr;
   endtask

   task automatic waitIssue(input string name, input logic [7:0] pcWant, input int maxCycles);
      int n;
      n = 0;
      @(negedge clk);
      while (!(decValid && decPc == pcWant) && n < maxCycles) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, {23'd0, decValid, decPc}, {23'd0, 1'b1, pcWant});
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && decValid && decReady) begin
         if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_issue: got pc=0x%0h op=%0d, expected nothing", decPc, decOpcode);
         end else begin
            e = expQ.pop_front();
            checkOutput("sb_opcode",  32'(decOpcode),  32'(e.op));
            checkOutput("sb_rd",      32'(decRd),      32'(e.rd));
            checkOutput("sb_rs",      32'(decRs),      32'(e.rs));
            checkOutput("sb_operand", 32'(decOperand), 32'(e.operand));
            checkOutput("sb_pc",      32'(decPc),      32'(e.pc));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      compared     = 0;
      mismatched   = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'hA0;
      mem[8'h01] = 8'd30;
      mem[8'h02] = 8'h06;
      mem[8'h03] = 8'h88;
      mem[8'h04] = 8'h55;
      mem[8'h05] = 8'h13;
      mem[8'h06] = 8'h7D;
      mem[8'h07] = 8'hC5;
      mem[8'h08] = 8'h99;
      mem[8'h09] = 8'h92;
      mem[8'h0A] = 8'h11;
      mem[8'd40] = 8'h5B;
      mem[8'hFF] = 8'hD0;

      rst          = 1'b1;
      decReady     = 1'b1;
      redirect     = 1'b0;
      redirectAddr = 8'd0;

      $display("[TB] reset state");
      repeat (3) @(negedge clk);
      checkOutput("rst_mem_rd",    32'(memRd),      32'd0);
      checkOutput("rst_dec_valid", 32'(decValid),   32'd0);
      checkOutput("rst_fields",    {12'd0, decOpcode, decRd, decRs, decOperand}, 32'd0);
      checkOutput("rst_dec_pc",    32'(decPc),      32'd0);

      $display("[TB] two-byte READI at 0");
      expQ.push_back('{op: 4'd10, rd: 2'd0, rs: 2'd0, operand: 8'd30, pc: 8'h00});
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      checkOutput("c0_fetch", {23'd0, memRd, memAddr}, {23'd0, 1'b1, 8'h00});
      applyStimulus(1'b1, 1'b0, 8'd0);
      @(negedge clk);
      checkOutput("c1_opfetch", {23'd0, memRd, memAddr}, {23'd0, 1'b1, 8'h01});
      applyStimulus(1'b1, 1'b0, 8'd0);
      @(negedge clk);
      checkOutput("c2_no_valid", {30'd0, decValid, memRd}, 32'd0);
      applyStimulus(1'b1, 1'b0, 8'd0);
      @(negedge clk);
      checkOutput("c3_valid", 32'(decValid), 32'd1);
      applyStimulus(1'b1, 1'b0, 8'd0);
      @(negedge clk);
      checkOutput("next_fetch_2", {23'd0, memRd, memAddr}, {23'd0, 1'b1, 8'h02});

      $display("[TB] mixed stream up to one-byte REGD at 6");
      expQ.push_back('{op: 4'd0, rd: 2'd1, rs: 2'd2, operand: 8'h00, pc: 8'h02});
      expQ.push_back('{op: 4'd8, rd: 2'd2, rs: 2'd0, operand: 8'h55, pc: 8'h03});
      expQ.push_back('{op: 4'd1, rd: 2'd0, rs: 2'd3, operand: 8'h00, pc: 8'h05});
      expQ.push_back('{op: 4'd7, rd: 2'd3, rs: 2'd1, operand: 8'h00, pc: 8'h06});
      waitIssue("issue_pc6", 8'h06, 40);
      applyStimulus(1'b1, 1'b0, 8'd0);
      @(negedge clk);
      checkOutput("next_fetch_7", {23'd0, memRd, memAddr}, {23'd0, 1'b1, 8'h07});

      $display("[TB] backpressure in ISSUE");
      decReady = 1'b0;
      expQ.push_back('{op: 4'd12, rd: 2'd1, rs: 2'd1, operand: 8'h99, pc: 8'h07});
      waitIssue("issue_pc7", 8'h07, 20);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("hold_valid_nord", {30'd0, decValid, memRd}, {30'd0, 1'b1, 1'b0});
         checkOutput("hold_fields", {4'd0, decOpcode, decRd, decRs, decOperand, decPc},
                     {4'd0, 4'd12, 2'd1, 2'd1, 8'h99, 8'h07});
      end
      applyStimulus(1'b1, 1'b0, 8'd0);
      applyStimulus(1'b1, 1'b0, 8'd0);
      @(negedge clk);
      checkOutput("fetch_after_ready", {23'd0, memRd, memAddr}, {23'd0, 1'b1, 8'h09});

      $display("[TB] redirect during IMM");
      applyStimulus(1'b1, 1'b0, 8'd0);
      applyStimulus(1'b1, 1'b1, 8'd40);
      @(negedge clk);
      checkOutput("imm_idle", {23'd0, memRd, memAddr}, {23'd0, 1'b0, 8'h09});
      applyStimulus(1'b1, 1'b0, 8'd0);
      @(negedge clk);
      checkOutput("redirect_fetch", {22'd0, decValid, memRd, memAddr}, {22'd0, 1'b0, 1'b1, 8'd40});

      $display("[TB] redirect with accept, then JMP at 0xFF");
      expQ.push_back('{op: 4'd5, rd: 2'd2, rs: 2'd3, operand: 8'h00, pc: 8'd40});
      expQ.push_back('{op: 4'd13, rd: 2'd0, rs: 2'd0, operand: 8'hA0, pc: 8'hFF});
      applyStimulus(1'b1, 1'b0, 8'd0);
      applyStimulus(1'b1, 1'b1, 8'hFF);
      applyStimulus(1'b1, 1'b0, 8'd0);
      @(negedge clk);
      checkOutput("fetch_ff", {23'd0, memRd, memAddr}, {23'd0, 1'b1, 8'hFF});
      applyStimulus(1'b1, 1'b0, 8'd0);
      @(negedge clk);
      checkOutput("wrap_operand_addr", {23'd0, memRd, memAddr}, {23'd0, 1'b1, 8'h00});
      applyStimulus(1'b1, 1'b0, 8'd0);
      applyStimulus(1'b1, 1'b0, 8'd0);
      @(negedge clk);
      checkOutput("jmp_valid", 32'(decValid), 32'd1);
      applyStimulus(1'b1, 1'b0, 8'd0);
      @(negedge clk);
      checkOutput("wrap_next_fetch", {23'd0, memRd, memAddr}, {23'd0, 1'b1, 8'h01});

      $display("[TB] reset during DEC");
      applyStimulus(1'b1, 1'b0, 8'd0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_ctrl", {30'd0, decValid, memRd}, 32'd0);
      checkOutput("async_rst_fields", {4'd0, decOpcode, decRd, decRs, decOperand, decPc}, 32'd0);
      @(posedge clk); #1; rst = 1'b0;
      expQ.push_back('{op: 4'd10, rd: 2'd0, rs: 2'd0, operand: 8'd30, pc: 8'h00});
      @(negedge clk);
      checkOutput("restart_fetch", {23'd0, memRd, memAddr}, {23'd0, 1'b1, 8'h00});

      n = 0;
      while (expQ.size() != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("drain", 32'(expQ.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
